// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, coefficient indices and arithmetic helpers for the biquad cascade
// Contents: FSM state enum, coefficient slot indices, accumulator width function,
//           round/saturate function used at section writeback.
package iir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2,
        S_OUT  = 2'd3
    } iir_state_e;

    // Coefficient slot within a section: address = sect*5 + slot.
    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    // Widest accumulator / sample the helper below can handle.
    localparam int MAX_ACC_W  = 128;
    localparam int MAX_DATA_W = 64;

    // Five products of DATA_W x COEF_W need 3 guard bits.
    function automatic int acc_w(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

    // Round half up, drop frac_w fraction bits, clamp to a data_w signed range.
    // Callers sign-extend into MAX_ACC_W and truncate the result to their width.
    function automatic logic signed [MAX_DATA_W-1:0] round_sat(
        input logic signed [MAX_ACC_W-1:0] acc,
        input int                          frac_w,
        input int                          data_w
    );
        logic signed [MAX_ACC_W-1:0] one;
        logic signed [MAX_ACC_W-1:0] shifted;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        one     = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        shifted = (acc + (one <<< (frac_w - 1))) >>> frac_w;
        hi      = (one <<< (data_w - 1)) - one;
        lo      = -(one <<< (data_w - 1));
        if (shifted > hi) begin
            return hi[MAX_DATA_W-1:0];
        end else if (shifted < lo) begin
            return lo[MAX_DATA_W-1:0];
        end
        return shifted[MAX_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// rtl/iir_biquad_cascade_if.sv - sample streams and coefficient write bus of the biquad cascade
// Signals: in_valid/in_ready/in_data (sample in), out_valid/out_ready/out_data (sample out),
//          coef_we/coef_addr/coef_data (coefficient write). master = producer side, slave = filter.
interface iir_biquad_cascade_if #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared registered multiplier and accumulator with round/saturate output
// Ports: clk, reset_l (async active-low), en_i (product valid this cycle), first_i (first
//        product of a section: restart accumulation), neg_i (product is a feedback term),
//        a_i (sample), b_i (coefficient), y_o (rounded, saturated section result).
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int FRAC_W = 30
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic                     neg_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [DATA_W-1:0] y_o
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W);

    logic signed [PROD_W-1:0] prod_q;
    logic                     neg_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  sum;

    // The product lags its operands by one cycle, so each cycle folds in the
    // previous product. The fifth product is added combinationally in sum,
    // which the writeback cycle consumes directly.
    always_comb begin
        term = neg_q ? -ACC_W'(prod_q) : ACC_W'(prod_q);
        sum  = acc_q + term;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            prod_q <= '0;
            neg_q  <= 1'b0;
            acc_q  <= '0;
        end else if (en_i) begin
            prod_q <= PROD_W'(a_i) * PROD_W'(b_i);
            neg_q  <= neg_i;
            // prod_q still holds the previous section's last term here; discard it.
            acc_q  <= first_i ? '0 : sum;
        end
    end

    assign y_o = DATA_W'(round_sat(MAX_ACC_W'(sum), FRAC_W, DATA_W));

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - cascade of direct-form-I biquads sharing one MAC unit
// Ports: clk, reset_l (async active-low), clr (sync clear of delay lines, aborts sample),
//        busy (high when not idle), bus (slave: sample streams and coefficient writes).
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int FRAC_W = 30,
    parameter int N_SECT = 2
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                clr,
    output logic                busy,
    iir_biquad_cascade_if.slave bus
);
    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_MAC  = S_MAC;
    localparam logic [1:0] ST_WB   = S_WB;
    localparam logic [1:0] ST_OUT  = S_OUT;

    localparam int N_COEF = 5 * N_SECT;
    localparam int CIDX_W = $clog2(N_COEF);
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_W;

    logic [1:0]               state_q, state_d;
    logic [SECT_W-1:0]        sect_q, sect_d;
    logic [2:0]               k_q, k_d;
    logic                     ready_q;
    logic signed [COEF_W-1:0] coef_q [N_COEF];
    logic signed [DATA_W-1:0] x1_q [N_SECT];
    logic signed [DATA_W-1:0] x2_q [N_SECT];
    logic signed [DATA_W-1:0] y1_q [N_SECT];
    logic signed [DATA_W-1:0] y2_q [N_SECT];
    logic signed [DATA_W-1:0] x_cur_q;
    logic signed [DATA_W-1:0] out_data_q;

    logic                     in_ready;
    logic                     accept;
    logic                     last_sect;
    logic [CIDX_W-1:0]        coef_idx;
    logic signed [DATA_W-1:0] op_x;
    logic signed [COEF_W-1:0] op_c;
    logic signed [DATA_W-1:0] mac_y;
    logic                     mac_en;
    logic                     mac_first;
    logic                     mac_neg;

    // ready_q keeps in_ready low until the first clock after reset release.
    assign in_ready      = ready_q && (state_q == ST_IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != ST_IDLE);

    assign accept    = bus.in_valid && in_ready;
    assign last_sect = (int'(sect_q) == N_SECT - 1);
    assign coef_idx  = CIDX_W'(int'(sect_q) * 5 + int'(k_q));
    assign op_c      = coef_q[coef_idx];
    assign mac_en    = (state_q == ST_MAC);
    assign mac_first = (k_q == B0);
    assign mac_neg   = (k_q >= A1);

    always_comb begin
        op_x = '0;
        case (k_q)
            B0:      op_x = x_cur_q;
            B1:      op_x = x1_q[sect_q];
            B2:      op_x = x2_q[sect_q];
            A1:      op_x = y1_q[sect_q];
            A2:      op_x = y2_q[sect_q];
            default: op_x = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sect_d  = sect_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_MAC;
                    sect_d  = '0;
                    k_d     = B0;
                end
            end
            ST_MAC: begin
                if (k_q == A2) begin
                    state_d = ST_WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_WB: begin
                k_d = B0;
                if (last_sect) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_MAC;
                    sect_d  = sect_q + SECT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            k_d     = B0;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            sect_q  <= '0;
            k_q     <= B0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sect_q  <= sect_d;
            k_q     <= k_d;
            ready_q <= 1'b1;
        end
    end

    // Writes are honoured only while idle so a sample never sees a mix of old
    // and new coefficients.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= (i % 5 == int'(B0)) ? COEF_ONE : '0;
            end
        end else if (bus.coef_we && (state_q == ST_IDLE) && (int'(bus.coef_addr) < N_COEF)) begin
            coef_q[bus.coef_addr] <= $signed(bus.coef_data);
        end
    end

    // x_cur_q carries the input of the section being computed: the accepted
    // sample for section 0, then each section's output for the next one.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int s = 0; s < N_SECT; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
            x_cur_q    <= '0;
            out_data_q <= '0;
        end else if (clr) begin
            for (int s = 0; s < N_SECT; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else begin
            if (accept) begin
                x_cur_q <= $signed(bus.in_data);
            end
            if (state_q == ST_WB) begin
                x2_q[sect_q] <= x1_q[sect_q];
                x1_q[sect_q] <= x_cur_q;
                y2_q[sect_q] <= y1_q[sect_q];
                y1_q[sect_q] <= mac_y;
                x_cur_q      <= mac_y;
                if (last_sect) begin
                    out_data_q <= mac_y;
                end
            end
        end
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk     (clk),
        .reset_l (reset_l),
        .en_i    (mac_en),
        .first_i (mac_first),
        .neg_i   (mac_neg),
        .a_i     (op_x),
        .b_i     (op_c),
        .y_o     (mac_y)
    );

endmodule
